// File: rtl/vector_loader.sv
// vector_loader: assembles a framed element stream into two vectors for a dot-product consumer
module vector_loader #(
  parameter int ELEMENT_WIDTH    = 64,
  parameter int VECTOR_DIMENSION = 10
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      in_valid,
  input  logic [ELEMENT_WIDTH-1:0]                  in_data,
  input  logic                                      in_last,
  output logic                                      in_ready,
  output logic [ELEMENT_WIDTH*VECTOR_DIMENSION-1:0] vec0,
  output logic [ELEMENT_WIDTH*VECTOR_DIMENSION-1:0] vec1,
  output logic                                      vec_valid,
  input  logic                                      vec_ready,
  output logic                                      frame_err,
  output logic [15:0]                               frame_count
);
  localparam int IW = $clog2(VECTOR_DIMENSION);
  typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;
  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic          accept, at_end, final_beat, early_last, missing_last, done;
  assign at_end = idx == IW'(VECTOR_DIMENSION - 1);
  always_comb begin
    in_ready     = state != HOLD;
    vec_valid    = state == HOLD;
    accept       = in_valid && in_ready;
    final_beat   = state == LOAD_B && at_end;
    early_last   = accept && in_last && !final_beat;
    missing_last = accept && !in_last && final_beat;
    done         = accept && final_beat;
    state_n      = state;
    idx_n        = idx;
    if (state == HOLD) begin
      state_n = vec_ready ? LOAD_A : HOLD;
      idx_n   = '0;
    end else if (early_last) begin
      state_n = LOAD_A;
      idx_n   = '0;
    end else if (accept) begin
      idx_n   = at_end ? '0 : idx + 1'b1;
      state_n = !at_end ? state : (state == LOAD_A ? LOAD_B : HOLD);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD_A;
      idx         <= '0;
      vec0        <= '0;
      vec1        <= '0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      frame_err <= early_last || missing_last;
      if (done) frame_count <= frame_count + 16'd1;
      if (accept && state == LOAD_A) vec0[idx*ELEMENT_WIDTH +: ELEMENT_WIDTH] <= in_data;
      if (accept && state == LOAD_B) vec1[idx*ELEMENT_WIDTH +: ELEMENT_WIDTH] <= in_data;
    end
  end
endmodule

// File: doc/vector_loader.md
VECTOR_LOADER -- requirements
Module: vector_loader

Interface
REQ-001 SHALL have parameter ELEMENT_WIDTH, default 64, meaning bit width of one fixed-point element.
REQ-002 SHALL have parameter VECTOR_DIMENSION, default 10, meaning elements per vector (legal range >= 2).
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  element beat on in_data is valid.
REQ-006 SHALL have port in_data  input  ELEMENT_WIDTH  signed element, two's complement.
REQ-007 SHALL have port in_last  input  1  marks final beat of a frame.
REQ-008 SHALL have port in_ready  output  1  loader accepts a beat this cycle.
REQ-009 SHALL have port vec0  output  ELEMENT_WIDTH*VECTOR_DIMENSION  first vector, element i at bits [i*ELEMENT_WIDTH +: ELEMENT_WIDTH].
REQ-010 SHALL have port vec1  output  ELEMENT_WIDTH*VECTOR_DIMENSION  second vector, same packing.
REQ-011 SHALL have port vec_valid  output  1  vec0/vec1 hold a complete frame.
REQ-012 SHALL have port vec_ready  input  1  downstream dot-product consumer accepts the frame.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse on framing error.
REQ-014 SHALL have port frame_count  output  16  count of completed frames, wraps 0xFFFF -> 0x0000.

Function
REQ-015 SHALL implement states LOAD_A, LOAD_B, HOLD and an element index idx in 0..VECTOR_DIMENSION-1.
REQ-016 SHALL drive in_ready = 1 in LOAD_A/LOAD_B, 0 in HOLD; beat accepted iff in_valid && in_ready.
REQ-017 SHALL, on accepted beat in LOAD_A, write in_data to vec0[idx]; idx+1, or at idx = N-1: idx <- 0, state -> LOAD_B.
REQ-018 SHALL, on accepted beat in LOAD_B, write in_data to vec1[idx]; idx+1, or at idx = N-1: state -> HOLD, frame_count+1.
REQ-019 SHALL assert vec_valid exactly in HOLD, i.e. first cycle after final beat accepted (latency 1 cycle).
REQ-020 SHALL keep vec0/vec1 stable while vec_valid = 1; no beats accepted in HOLD.
REQ-021 SHALL, in HOLD with vec_ready = 1, go to LOAD_A with idx <- 0; vec_valid low and in_ready high next cycle; no same-cycle load-through.
REQ-022 SHALL ignore vec_ready outside HOLD.
REQ-023 SHALL, on accepted in_last before final beat (early last): discard frame, idx <- 0, state -> LOAD_A, pulse frame_err next cycle, frame_count unchanged; partially written elements keep new values.
REQ-024 SHALL, on final beat without in_last (missing last): complete frame normally (HOLD, count+1) and pulse frame_err next cycle.
REQ-025 SHALL ignore in_data/in_last when beat not accepted; idle cycles (in_valid = 0) mid-frame SHALL NOT change state.
REQ-026 SHALL store data bit-exact; no arithmetic, truncation or sign change.

Reset
REQ-027 SHALL, when reset = 1 at a clock edge, set state LOAD_A, idx 0, vec0/vec1 all zero, vec_valid 0, frame_err 0, frame_count 0.
REQ-028 SHALL give reset priority over all inputs; reset mid-frame or in HOLD discards the frame without frame_err.
REQ-029 SHALL present in_ready = 1 on first cycle after reset deasserts.

Verification (ELEMENT_WIDTH=16, VECTOR_DIMENSION=4)
REQ-030 Back-to-back 8 beats 1..8, last on 8th, vec_ready=0 -> vec0={1,2,3,4}, vec1={5,6,7,8}, vec_valid 1 cycle after beat 8, in_ready 0, frame_count=1, frame_err never.
REQ-031 Hold 5 cycles then vec_ready=1 for 1 cycle -> vec_valid low next cycle, in_ready high; new frame 0xFFFF,0x8000,... loads bit-exact.
REQ-032 in_last on 3rd beat -> frame_err pulse 1 cycle, frame_count unchanged, next 8 beats 10..17 give vec0={10..13}, vec1={14..17}.
REQ-033 8 beats no in_last -> frame completes, frame_err 1-cycle pulse, frame_count+1.
REQ-034 Reset asserted after beat 5 -> all outputs zero, frame_count 0; following full frame loads correctly from vec0[0].
REQ-035 Preload frame_count 0xFFFF via 65535 frames (or forced) -> next completion wraps to 0x0000; random in_valid gaps give identical vectors.
